// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a 2-entry skid buffer and valid/ready on both
// sides. Upstream ready is registered, so there is no combinational path from
// m_ready_i to s_ready_o. A flush empties the stage and drives DEFAULT.
module pipe_stage_skid #(
  parameter int              DW      = 32,
  parameter logic [DW-1:0]   DEFAULT = {DW{1'b0}}
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          s_valid_i,
  output logic          s_ready_o,
  input  logic [DW-1:0] s_data_i,
  output logic          m_valid_o,
  input  logic          m_ready_i,
  output logic [DW-1:0] m_data_o,
  output logic [1:0]    count_o,
  output logic          drop_o
);

  typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1, SKID = 2'd2} state_t;

  state_t        r_state, w_state_nx;
  logic [DW-1:0] r_main, w_main_nx;
  logic [DW-1:0] r_skid, w_skid_nx;
  logic          r_ready;
  logic          r_drop;
  logic          w_in, w_out, w_drop_nx;

  // Handshakes as seen at the coming edge.
  assign w_in  = s_valid_i & r_ready;
  assign w_out = (r_state != EMPTY) & m_ready_i;

  // Main always holds DEFAULT while empty, so the output needs no mux.
  assign m_valid_o = (r_state != EMPTY);
  assign m_data_o  = r_main;
  assign s_ready_o = r_ready;
  assign drop_o    = r_drop;

  // Occupancy straight from the state encoding.
  always_comb begin
    count_o = 2'd0;
    case (r_state)
      FULL:    count_o = 2'd1;
      SKID:    count_o = 2'd2;
      default: count_o = 2'd0;
    endcase
  end

  // Next-state and next-payload selection; flush overrides every transfer.
  always_comb begin
    w_state_nx = r_state;
    w_main_nx  = r_main;
    w_skid_nx  = r_skid;
    w_drop_nx  = 1'b0;
    if (flush_i) begin
      w_state_nx = EMPTY;
      w_main_nx  = DEFAULT;
      w_skid_nx  = DEFAULT;
      w_drop_nx  = (r_state != EMPTY) | w_in;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in) begin
            w_main_nx  = s_data_i;
            w_state_nx = FULL;
          end
        end
        FULL: begin
          if (w_in && w_out) begin
            w_main_nx = s_data_i;
          end else if (w_in) begin
            w_skid_nx  = s_data_i;
            w_state_nx = SKID;
          end else if (w_out) begin
            w_main_nx  = DEFAULT;
            w_state_nx = EMPTY;
          end
        end
        SKID: begin
          // Ready is low here, so only the drain side can move.
          if (w_out) begin
            w_main_nx  = r_skid;
            w_skid_nx  = DEFAULT;
            w_state_nx = FULL;
          end
        end
        default: begin
          w_state_nx = EMPTY;
          w_main_nx  = DEFAULT;
          w_skid_nx  = DEFAULT;
        end
      endcase
    end
  end

  // State, payload, registered ready and drop pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= EMPTY;
      r_main  <= DEFAULT;
      r_skid  <= DEFAULT;
      r_ready <= 1'b1;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_main  <= w_main_nx;
      r_skid  <= w_skid_nx;
      r_ready <= (w_state_nx != SKID);
      r_drop  <= w_drop_nx;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and randomized checks for pipe_stage_skid with a NOP default word.
module tb_pipe_stage_skid;
  localparam int          DW  = 32;
  localparam logic [31:0] DEF = 32'h00000013;

  logic          clk = 1'b0;
  logic          rst, flush_i, s_valid_i, m_ready_i;
  logic [DW-1:0] s_data_i;
  logic          s_ready_o, m_valid_o, drop_o;
  logic [DW-1:0] m_data_o;
  logic [1:0]    count_o;

  int errors = 0;
  int checks = 0;

  pipe_stage_skid #(.DW(DW), .DEFAULT(DEF)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o),
    .count_o(count_o), .drop_o(drop_o)
  );

  always #5 clk = ~clk;

  // Advance one edge; outputs are inspected 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush_i = 0; s_valid_i = 0; m_ready_i = 0; s_data_i = '0;
    #3;
    checks++; if (m_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", m_valid_o); end
    checks++; if (m_data_o !== DEF) begin errors++; $display("FAIL reset_data got=%h exp=%h", m_data_o, DEF); end
    checks++; if (s_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", s_ready_o); end
    checks++; if (count_o !== 2'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count_o); end
    checks++; if (drop_o !== 1'b0) begin errors++; $display("FAIL reset_drop got=%b exp=0", drop_o); end
    step();
    rst = 1'b0;
    step();
    checks++; if (m_valid_o !== 1'b0 || m_data_o !== DEF) begin errors++; $display("FAIL idle got=%b/%h exp=0/%h", m_valid_o, m_data_o, DEF); end
  endtask

  task automatic test_stream();
    logic [31:0] v;
    m_ready_i = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      v = i;
      s_valid_i = 1'b1; s_data_i = v;
      step();
      checks++; if (m_valid_o !== 1'b1 || m_data_o !== v) begin errors++; $display("FAIL stream_data%0d got=%b/%h exp=1/%h", i, m_valid_o, m_data_o, v); end
      checks++; if (count_o !== 2'd1 || s_ready_o !== 1'b1) begin errors++; $display("FAIL stream_cnt%0d got=%0d/%b exp=1/1", i, count_o, s_ready_o); end
    end
    s_valid_i = 1'b0;
    step();
    checks++; if (m_valid_o !== 1'b0 || m_data_o !== DEF || count_o !== 2'd0) begin errors++; $display("FAIL stream_end got=%b/%h/%0d exp=0/%h/0", m_valid_o, m_data_o, count_o, DEF); end
  endtask

  task automatic test_skid();
    m_ready_i = 1'b0;
    s_valid_i = 1'b1; s_data_i = 32'hA;
    step();
    checks++; if (count_o !== 2'd1 || s_ready_o !== 1'b1 || m_data_o !== 32'hA) begin errors++; $display("FAIL skid_a got=%0d/%b/%h exp=1/1/a", count_o, s_ready_o, m_data_o); end
    s_data_i = 32'hB;
    step();
    checks++; if (count_o !== 2'd2 || s_ready_o !== 1'b0 || m_data_o !== 32'hA) begin errors++; $display("FAIL skid_b got=%0d/%b/%h exp=2/0/a", count_o, s_ready_o, m_data_o); end
    s_valid_i = 1'b0;
    step();
    checks++; if (count_o !== 2'd2 || m_valid_o !== 1'b1 || m_data_o !== 32'hA) begin errors++; $display("FAIL skid_hold got=%0d/%b/%h exp=2/1/a", count_o, m_valid_o, m_data_o); end
    m_ready_i = 1'b1;
    step();
    checks++; if (count_o !== 2'd1 || s_ready_o !== 1'b1 || m_data_o !== 32'hB) begin errors++; $display("FAIL drain1 got=%0d/%b/%h exp=1/1/b", count_o, s_ready_o, m_data_o); end
    step();
    checks++; if (count_o !== 2'd0 || m_valid_o !== 1'b0 || m_data_o !== DEF) begin errors++; $display("FAIL drain2 got=%0d/%b/%h exp=0/0/%h", count_o, m_valid_o, m_data_o, DEF); end
    m_ready_i = 1'b0;
  endtask

  task automatic test_flush_skid();
    m_ready_i = 1'b0;
    s_valid_i = 1'b1; s_data_i = 32'hC; step();
    s_data_i = 32'hD; step();
    s_valid_i = 1'b0;
    checks++; if (count_o !== 2'd2) begin errors++; $display("FAIL fl_pre got=%0d exp=2", count_o); end
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    checks++; if (m_valid_o !== 1'b0 || m_data_o !== DEF || count_o !== 2'd0) begin errors++; $display("FAIL fl_skid got=%b/%h/%0d exp=0/%h/0", m_valid_o, m_data_o, count_o, DEF); end
    checks++; if (drop_o !== 1'b1 || s_ready_o !== 1'b1) begin errors++; $display("FAIL fl_drop got=%b/%b exp=1/1", drop_o, s_ready_o); end
    step();
    checks++; if (drop_o !== 1'b0 || m_valid_o !== 1'b0) begin errors++; $display("FAIL fl_pulse got=%b/%b exp=0/0", drop_o, m_valid_o); end
  endtask

  task automatic test_flush_input();
    m_ready_i = 1'b1;
    // Flush of an empty stage with no input drops nothing.
    flush_i = 1'b1;
    step();
    checks++; if (drop_o !== 1'b0) begin errors++; $display("FAIL fl_empty got=%b exp=0", drop_o); end
    // Held flush with input: every accepted word is discarded.
    s_valid_i = 1'b1; s_data_i = 32'h55;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (drop_o !== 1'b1 || count_o !== 2'd0 || m_valid_o !== 1'b0 || s_ready_o !== 1'b1) begin errors++; $display("FAIL fl_in%0d got=%b/%0d/%b/%b exp=1/0/0/1", i, drop_o, count_o, m_valid_o, s_ready_o); end
      checks++; if (m_data_o === 32'h55) begin errors++; $display("FAIL fl_leak%0d got=%h exp=%h", i, m_data_o, DEF); end
    end
    flush_i = 1'b0; s_valid_i = 1'b0;
    step();
    checks++; if (drop_o !== 1'b0 || m_valid_o !== 1'b0 || m_data_o !== DEF) begin errors++; $display("FAIL fl_after got=%b/%b/%h exp=0/0/%h", drop_o, m_valid_o, m_data_o, DEF); end
  endtask

  task automatic test_random();
    logic [31:0] q[$];
    logic [31:0] exp_w;
    logic        in_x, out_x;
    for (int c = 0; c < 10000; c++) begin
      s_valid_i = ($urandom_range(0, 3) != 0);
      m_ready_i = ($urandom_range(0, 2) != 0);
      s_data_i  = $urandom;
      #1;
      in_x  = s_valid_i & s_ready_o;
      out_x = m_valid_o & m_ready_i;
      if (out_x) begin
        exp_w = (q.size() > 0) ? q.pop_front() : DEF;
        checks++; if (m_data_o !== exp_w) begin errors++; $display("FAIL rnd_data c=%0d got=%h exp=%h", c, m_data_o, exp_w); end
      end
      if (in_x) q.push_back(s_data_i);
      step();
      checks++; if (count_o === 2'd3 || count_o !== q.size()) begin errors++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, count_o, q.size()); end
    end
    // Reset mid-stream: outputs return immediately, between edges.
    s_valid_i = 1'b1; m_ready_i = 1'b0; s_data_i = 32'h77;
    step(); step();
    #2 rst = 1'b1;
    #1;
    checks++; if (m_valid_o !== 1'b0 || m_data_o !== DEF || s_ready_o !== 1'b1 || count_o !== 2'd0 || drop_o !== 1'b0) begin errors++; $display("FAIL mid_rst got=%b/%h/%b/%0d/%b exp=0/%h/1/0/0", m_valid_o, m_data_o, s_ready_o, count_o, drop_o, DEF); end
    s_valid_i = 1'b0;
    step();
    rst = 1'b0;
    step();
    checks++; if (m_valid_o !== 1'b0 || count_o !== 2'd0) begin errors++; $display("FAIL post_rst got=%b/%0d exp=0/0", m_valid_o, count_o); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_skid();
    test_flush_skid();
    test_flush_input();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised pipeline stage register, successor to the fixed-width flush/hold stage registers between core pipeline stages.
- Uses a valid/ready handshake on both sides instead of a global hold flag.
- Holds a 2-entry skid buffer, so upstream ready is a registered signal with no combinational path from downstream ready.
- A flush squashes all held entries and presents a configurable default word, for example a NOP encoding.

Parameters:
DW, 32, payload width in bits (1..256)
DEFAULT, {DW{1'b0}}, value driven on m_data_o when the stage is empty or flushed; stored in main/skid on reset and flush

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous reset, active-high
flush_i  input  1  synchronous squash of all held entries; priority over every transfer
s_valid_i  input  1  upstream payload valid
s_ready_o  output  1  stage can accept a word this cycle (registered)
s_data_i  input  DW  upstream payload
m_valid_o  output  1  downstream payload valid
m_ready_i  input  1  downstream accepts this cycle
m_data_o  output  DW  downstream payload; equals DEFAULT when m_valid_o=0
count_o  output  2  number of held entries, 0..2
drop_o  output  1  one-cycle pulse: flush discarded at least one valid entry or an accepted input

Behaviour:
- Reset (async, rst=1):
  - state=EMPTY, m_valid_o=0, s_ready_o=1, count_o=0, drop_o=0.
  - main and skid registers = DEFAULT; m_data_o=DEFAULT.
- Handshake definitions:
  - In-transfer = s_valid_i & s_ready_o.
  - Out-transfer = m_valid_o & m_ready_i.
  - A word is transferred only on a rising edge where its handshake is high.
- Output and ready timing:
  - m_data_o/m_valid_o are driven directly from the main register: zero-latency output, 1-cycle input-to-output latency.
  - s_ready_o = (state != SKID), registered.
- States: EMPTY (count 0), FULL (main valid, count 1), SKID (main+skid valid, count 2).
- Transitions when flush_i=0:
  - EMPTY: in-transfer -> main<=s_data_i, go FULL; else stay.
  - FULL, in & out -> main<=s_data_i, stay FULL.
  - FULL, in & !out -> skid<=s_data_i, go SKID.
  - FULL, !in & out -> main<=DEFAULT, go EMPTY.
  - FULL, neither -> hold all.
  - SKID: s_ready_o=0, so no in-transfer is possible.
  - SKID, out -> main<=skid, skid<=DEFAULT, go FULL.
  - SKID, !out -> hold all.
- Ordering: strictly FIFO. The skid entry is always older than any later input.
- Stability: payload and valid must not change while m_valid_o=1 & m_ready_i=0.
- flush_i=1 at an edge:
  - Next state EMPTY; main, skid <= DEFAULT; s_ready_o<=1.
  - Any in-transfer in the same cycle is discarded.
  - An out-transfer in the same cycle is still considered delivered downstream.
  - drop_o<=1 for one cycle if, before the edge, count_o>0 or an in-transfer occurred; else drop_o<=0.
- Flush held high for multiple cycles: stage stays EMPTY, s_ready_o=1, every accepted input is discarded, drop_o pulses each such cycle.
- drop_o is 0 in every non-flush cycle.
- Reset asserted mid-operation: immediate return to reset values regardless of state; no partial transfers complete.
- count_o tracks state exactly: EMPTY=0, FULL=1, SKID=2. Value 3 is illegal; the verification assertion must never see it.
- Throughput: sustains 1 word/cycle with m_ready_i tied high.
- Under arbitrary m_ready_i backpressure: no word lost or duplicated, except on flush.

Test Plan:
- Reset then idle: rst pulse with DEFAULT=32'h00000013 -> m_valid_o=0, m_data_o=32'h00000013, s_ready_o=1, count_o=0.
- Streaming: m_ready_i=1; push 0x1,0x2,0x3 on consecutive cycles -> m_data_o 0x1,0x2,0x3 one cycle later each, count_o stays 1, s_ready_o stays 1.
- Skid fill/drain: push 0xA then 0xB with m_ready_i=0 -> count_o=2, s_ready_o=0 the next cycle, m_data_o=0xA held. Raise m_ready_i -> 0xA then 0xB delivered in order, count_o 2->1->0, s_ready_o returns 1 after the first drain.
- Flush at SKID: with count_o=2, assert flush_i for one cycle while s_valid_i=0 -> next cycle m_valid_o=0, m_data_o=DEFAULT, count_o=0, drop_o=1 for exactly one cycle.
- Flush with simultaneous input: state EMPTY, s_valid_i=1, s_data_i=0x55, flush_i=1 -> 0x55 never appears on m_data_o, drop_o=1, count_o=0.
- Random backpressure plus async reset: random s_valid_i/m_ready_i over 10k cycles with a scoreboard -> in-order, lossless delivery, count_o never 3. rst asserted mid-stream -> outputs return to reset values within the same cycle.
